// File: rtl/ring_mod_pkg.sv
// Shared constants for the ring modulator: default sizes, fixed-point
// format of the carrier, and the quarter-wave-symmetric sine table.
package ring_mod_pkg;

    localparam int DATA_W_DEF  = 16;
    localparam int STEPS_DEF   = 32;
    localparam int PHASE_W_DEF = $clog2(STEPS_DEF);

    // Carrier is Q1.15: +/-32767 represents +/-1.0
    localparam int CARRIER_W  = 16;
    localparam int FRAC_SHIFT = 15;

    // Table holds one full period at 32 points; smaller STEPS values
    // subsample it by stepping through every (32/STEPS)-th entry.
    localparam int LUT_AW    = 5;
    localparam int LUT_DEPTH = 1 << LUT_AW;

    // Entry k = round(32767 * sin(2*pi*k/32))
    localparam logic signed [CARRIER_W-1:0] SINE_LUT [LUT_DEPTH] = '{
         16'sd0,      16'sd6393,   16'sd12539,  16'sd18204,
         16'sd23170,  16'sd27245,  16'sd30273,  16'sd32137,
         16'sd32767,  16'sd32137,  16'sd30273,  16'sd27245,
         16'sd23170,  16'sd18204,  16'sd12539,  16'sd6393,
         16'sd0,     -16'sd6393,  -16'sd12539, -16'sd18204,
        -16'sd23170, -16'sd27245, -16'sd30273, -16'sd32137,
        -16'sd32767, -16'sd32137, -16'sd30273, -16'sd27245,
        -16'sd23170, -16'sd18204, -16'sd12539, -16'sd6393
    };

    // Map a carrier phase of the given width onto a table address.
    function automatic logic [LUT_AW-1:0] lut_addr(input logic [LUT_AW-1:0] phase_ext,
                                                   input int phase_w);
        return phase_ext << (LUT_AW - phase_w);
    endfunction

endpackage

// File: rtl/ring_modulator_carrier_nco.sv
// Carrier NCO: a programmable step counter advances the table phase; the
// sine ROM is read with the next-state phase so the registered carrier is
// always aligned with the phase currently presented.
module carrier_nco
    import ring_mod_pkg::*;
#(
    parameter int STEPS = STEPS_DEF
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [31:0]                 frequency_i,
    output logic [$clog2(STEPS)-1:0]    phase_o,
    output logic signed [CARRIER_W-1:0] carrier_o
);

    localparam int PHASE_W = $clog2(STEPS);

    logic [31:0]                 step_q, step_d;
    logic [31:0]                 freq_lat_q, freq_lat_d;
    logic [PHASE_W-1:0]          phase_q, phase_d;
    logic signed [CARRIER_W-1:0] carrier_q;
    logic [31:0]                 last_step;
    logic                        rollover;

    // Next-state: count to freq_lat-1 (0 and 1 both mean every cycle), then
    // advance the phase and pick up a new step length only at the boundary.
    always_comb begin
        last_step  = (freq_lat_q > 32'd1) ? (freq_lat_q - 32'd1) : 32'd0;
        rollover   = (step_q >= last_step);
        step_d     = step_q + 32'd1;
        freq_lat_d = freq_lat_q;
        phase_d    = phase_q;
        if (rollover) begin
            step_d     = 32'd0;
            freq_lat_d = frequency_i;
            phase_d    = phase_q + PHASE_W'(1);
        end
    end

    // State registers plus registered ROM read addressed by the next phase.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            step_q     <= 32'd0;
            freq_lat_q <= frequency_i;
            phase_q    <= '0;
            carrier_q  <= SINE_LUT[0];
        end else begin
            step_q     <= step_d;
            freq_lat_q <= freq_lat_d;
            phase_q    <= phase_d;
            carrier_q  <= SINE_LUT[lut_addr(LUT_AW'(phase_d), PHASE_W)];
        end
    end

    assign phase_o   = phase_q;
    assign carrier_o = carrier_q;

endmodule

// File: rtl/ring_modulator.sv
// Ring modulator: multiplies each audio sample by the NCO sine carrier
// (Q1.15), with a bypass path of identical two-cycle latency.
module ring_modulator
    import ring_mod_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int STEPS  = STEPS_DEF
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [31:0]               frequency,
    input  logic                      disabled,
    input  logic signed [DATA_W-1:0]  sample_in,
    input  logic                      sample_valid,
    output logic signed [DATA_W-1:0]  sample_out,
    output logic                      out_valid,
    output logic [$clog2(STEPS)-1:0]  phase
);

    localparam int PROD_W = DATA_W + CARRIER_W;
    localparam int UPPER_W = PROD_W - DATA_W + 1;
    localparam logic signed [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    logic signed [CARRIER_W-1:0] carrier;

    logic                        s0_valid_q, s0_valid_d;
    logic                        s0_bypass_q, s0_bypass_d;
    logic signed [DATA_W-1:0]    s0_sample_q, s0_sample_d;
    logic signed [CARRIER_W-1:0] s0_carrier_q, s0_carrier_d;
    logic signed [DATA_W-1:0]    out_q, out_d;
    logic                        out_valid_q, out_valid_d;

    logic signed [PROD_W-1:0]    sample_ext, carrier_ext, product, shifted;
    logic [UPPER_W-1:0]          upper;
    logic signed [DATA_W-1:0]    mod_result;

    carrier_nco #(
        .STEPS      (STEPS)
    ) u_nco (
        .clk_i      (CLK),
        .rst_i      (RST),
        .frequency_i(frequency),
        .phase_o    (phase),
        .carrier_o  (carrier)
    );

    // Stage 0 capture: sample, carrier and bypass flag frozen together.
    always_comb begin
        s0_valid_d   = sample_valid;
        s0_bypass_d  = s0_bypass_q;
        s0_sample_d  = s0_sample_q;
        s0_carrier_d = s0_carrier_q;
        if (sample_valid) begin
            s0_bypass_d  = disabled;
            s0_sample_d  = sample_in;
            s0_carrier_d = carrier;
        end
    end

    // Stage 1: signed multiply, floor shift back to sample scale, saturate.
    always_comb begin
        sample_ext  = {{CARRIER_W{s0_sample_q[DATA_W-1]}}, s0_sample_q};
        carrier_ext = {{DATA_W{s0_carrier_q[CARRIER_W-1]}}, s0_carrier_q};
        product     = sample_ext * carrier_ext;
        shifted     = product >>> FRAC_SHIFT;
        upper       = shifted[PROD_W-1:DATA_W-1];
        if ((&upper) || !(|upper)) begin
            mod_result = shifted[DATA_W-1:0];
        end else begin
            mod_result = shifted[PROD_W-1] ? SAT_MIN : SAT_MAX;
        end
        out_valid_d = s0_valid_q;
        out_d       = out_q;
        if (s0_valid_q) begin
            out_d = s0_bypass_q ? s0_sample_q : mod_result;
        end
    end

    // Pipeline registers; reset drops anything in flight.
    always_ff @(posedge CLK) begin
        if (RST) begin
            s0_valid_q   <= 1'b0;
            s0_bypass_q  <= 1'b0;
            s0_sample_q  <= '0;
            s0_carrier_q <= '0;
            out_q        <= '0;
            out_valid_q  <= 1'b0;
        end else begin
            s0_valid_q   <= s0_valid_d;
            s0_bypass_q  <= s0_bypass_d;
            s0_sample_q  <= s0_sample_d;
            s0_carrier_q <= s0_carrier_d;
            out_q        <= out_d;
            out_valid_q  <= out_valid_d;
        end
    end

    assign sample_out = out_q;
    assign out_valid  = out_valid_q;

endmodule

// File: tb/tb_ring_modulator.sv
// Directed bench for ring_modulator: expected outputs are computed from a
// floating-point sine model, queued at drive time and checked on output.
module tb_ring_modulator;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [31:0] frequency = 32'd4;
    logic        disabled = 1'b0;
    logic [15:0] sample_in = 16'h0000;
    logic        sample_valid = 1'b0;
    logic [15:0] sample_out;
    logic        out_valid;
    logic [4:0]  phase;

    int          n_cmp = 0;
    int          n_fail = 0;
    int          cyc = 0;
    bit          rst_prev = 1'b0;
    logic [15:0] last_out = 16'h0000;

    typedef struct {
        logic [15:0] val;
        int          cyc;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    ring_modulator #(
        .DATA_W      (16),
        .STEPS       (32)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .frequency   (frequency),
        .disabled    (disabled),
        .sample_in   (sample_in),
        .sample_valid(sample_valid),
        .sample_out  (sample_out),
        .out_valid   (out_valid),
        .phase       (phase)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        cyc      <= cyc + 1;
        rst_prev <= RST;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    function automatic logic [15:0] model_out(input logic [15:0] s, input int ph, input logic dis);
        real    v;
        int     car;
        longint p;
        longint sh;
        if (dis) return s;
        v   = 32767.0 * $sin(2.0 * 3.14159265358979 * ph / 32.0);
        car = (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
        p   = longint'($signed(s)) * longint'(car);
        sh  = p >>> 15;
        if (sh > 32767) sh = 32767;
        else if (sh < -32768) sh = -32768;
        return sh[15:0];
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] d, input logic dis, input int ph);
        exp_t e;
        sample_valid = v;
        sample_in    = d;
        disabled     = dis;
        if (v) begin
            e.val = model_out(d, ph, dis);
            e.cyc = cyc + 2;
            sb_q.push_back(e);
        end
    endtask

    // Output monitor: reset clears, valid pops the scoreboard, idle holds.
    always @(negedge CLK) begin
        if (rst_prev) begin
            chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
            chk("rst_sample_out", {16'b0, sample_out}, 32'd0);
        end else if (out_valid) begin
            if (sb_q.size() == 0) begin
                chk("spurious_out_valid", {31'b0, out_valid}, 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                $display("out cyc=%0d sample_out=%h expect=%h", cyc, sample_out, mon_e.val);
                chk("sample_out", {16'b0, sample_out}, {16'b0, mon_e.val});
                chk("latency", cyc, mon_e.cyc);
            end
        end else begin
            chk("hold", {16'b0, sample_out}, {16'b0, last_out});
        end
        last_out = sample_out;
    end

    initial begin
        int          ph;
        logic        v;
        logic        dis;
        logic [15:0] d;

        // Reset with frequency 4
        tick();
        tick();
        chk("reset_phase", {27'b0, phase}, 32'd0);
        chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
        chk("reset_sample_out", {16'b0, sample_out}, 32'd0);
        RST = 1'b0;

        // Phase every 4 cycles, wrap at 128, modulate and bypass samples
        for (int c = 0; c < 140; c++) begin
            ph = (c / 4) % 32;
            chk("phase_f4", {27'b0, phase}, ph);
            v = 1'b0; d = 16'h0000; dis = 1'b0;
            if (c == 32 || c == 96 || c == 128) begin v = 1'b1; d = 16'h4000; end
            else if (c == 40) begin v = 1'b1; d = 16'h7FFF; end
            else if (c == 41) begin v = 1'b1; d = 16'h8000; end
            else if (c == 60) begin v = 1'b1; d = 16'h1234; end
            else if (c >= 70 && c <= 73) begin v = 1'b1; d = 16'($urandom); end
            else if (c == 80) begin v = 1'b1; d = 16'h8000; dis = 1'b1; end
            else if (c == 81) begin v = 1'b1; d = 16'h7FFF; dis = 1'b1; end
            drive(v, d, dis, ph);
            tick();
        end
        drive(1'b0, 16'h0000, 1'b0, 0);
        repeat (3) tick();
        chk("drain_f4", sb_q.size(), 32'd0);

        // frequency 0: phase advances every cycle
        RST = 1'b1;
        frequency = 32'd0;
        tick();
        RST = 1'b0;
        for (int c = 0; c < 40; c++) begin
            ph = c % 32;
            chk("phase_f0", {27'b0, phase}, ph);
            v = 1'b0; d = 16'h0000;
            if (c == 24) begin v = 1'b1; d = 16'h8000; end
            else if (c == 8) begin v = 1'b1; d = 16'h7FFF; end
            else if (c == 31) begin v = 1'b1; d = 16'h0001; end
            else if (c == 33) begin v = 1'b1; d = 16'h8000; end
            drive(v, d, 1'b0, ph);
            tick();
        end
        drive(1'b0, 16'h0000, 1'b0, 0);
        repeat (3) tick();
        chk("drain_f0", sb_q.size(), 32'd0);

        // Mid-step frequency change 3551 -> 100
        RST = 1'b1;
        frequency = 32'd3551;
        tick();
        RST = 1'b0;
        for (int c = 0; c < 3761; c++) begin
            ph = (c < 3551) ? 0 : (1 + (c - 3551) / 100);
            chk("phase_fchg", {27'b0, phase}, ph);
            if (c == 10) frequency = 32'd100;
            tick();
        end

        // Reset one cycle after a sample: it must never emerge
        ph = 1 + (3761 - 3551) / 100;
        chk("phase_pre_rst", {27'b0, phase}, ph);
        drive(1'b1, 16'h4000, 1'b0, ph);
        tick();
        sample_valid = 1'b0;
        RST = 1'b1;
        sb_q.delete();
        tick();
        RST = 1'b0;
        chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("midrst_sample_out", {16'b0, sample_out}, 32'd0);
        chk("midrst_phase", {27'b0, phase}, 32'd0);
        repeat (4) tick();
        chk("post_rst_phase", {27'b0, phase}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
